lc3_mem_access: RTL and testbench

//  LC-3 memory-access stage; sits directly downstream of the execute stage.

---
 rtl/lc3_mem_access_pkg.sv | 32 +++
 rtl/lc3_mem_access_if.sv | 32 +++
 rtl/lc3_mem_watchdog.sv | 36 +++
 rtl/lc3_mem_access.sv | 169 ++++++++++++++++
 tb/tb_lc3_mem_access.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lc3_mem_access_pkg.sv
// Shared LC-3 memory-stage definitions: opcode encodings, FSM state type and opcode decode helpers.
package lc3_pkg_hdl;

  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_STI = 4'b1011;

  typedef enum logic [1:0] {
    IDLE,
    IND_RD,
    RD,
    WR
  } mem_state_t;

  function automatic logic is_mem_op(input logic [3:0] op);
    logic hit;
    hit = 1'b0;
    case (op)
      OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI: hit = 1'b1;
      default:                                       hit = 1'b0;
    endcase
    return hit;
  endfunction

  function automatic logic is_store_op(input logic [3:0] op);
    return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
  endfunction

endpackage

// File: rtl/lc3_mem_access_if.sv
// Data-memory req/ack port between the LC-3 memory stage (master) and data memory (slave).
interface lc3_mem_access_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  rdata,
    input  ack
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output rdata,
    output ack
  );

endinterface

// File: rtl/lc3_mem_watchdog.sv
// Ack watchdog for the LC-3 memory stage: counts busy cycles without an ack and flags expiry.
module lc3_mem_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clock,
  input  logic reset,
  input  logic active,
  input  logic ack,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Expiry on the last allowed cycle so the abort lands exactly TIMEOUT_CYCLES after req rose.
  assign expired = active && !ack && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!active || ack || expired) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lc3_mem_access.sv
// LC-3 memory-access stage: LD/LDR/LDI reads and ST/STR/STI writes over a req/ack port.
// Optional ack watchdog enabled by defining LC3_MEM_TIMEOUT_EN.
module lc3_mem_access
  import lc3_pkg_hdl::*;
#(
  parameter int unsigned ADDR_W         = 16,
  parameter int unsigned DATA_W         = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable_mem,
  input  logic [15:0]           IR_Exec,
  input  logic                  Mem_Control_out,
  input  logic [ADDR_W-1:0]     pcout,
  input  logic [DATA_W-1:0]     M_Data,
  lc3_mem_access_if.master      dmem,
  output logic [DATA_W-1:0]     memout,
  output logic                  mem_valid,
  output logic                  store_done,
  output logic                  stall,
  output logic                  mem_err
);

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] memout_q, memout_d;
  logic              is_store_q, is_store_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic              mem_valid_q, mem_valid_d;
  logic              store_done_q, store_done_d;
  logic              mem_err_q, mem_err_d;
  logic              accept;
  logic              expired;
  logic [3:0]        opcode;

  assign opcode = IR_Exec[15:12];
  assign accept = enable_mem && is_mem_op(opcode);

  logic unused_ir;
  assign unused_ir = ^IR_Exec[11:0];

`ifdef LC3_MEM_TIMEOUT_EN
  lc3_mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .active (state_q != IDLE),
    .ack    (dmem.ack),
    .expired(expired)
  );
`else
  localparam int unsigned UnusedTimeoutCycles = TIMEOUT_CYCLES;
  assign expired = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    memout_d     = memout_q;
    is_store_d   = is_store_q;
    req_d        = req_q;
    we_d         = we_q;
    mem_valid_d  = 1'b0;
    store_done_d = 1'b0;
    mem_err_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          addr_d     = pcout;
          wdata_d    = M_Data;
          is_store_d = is_store_op(opcode);
          req_d      = 1'b1;
          if (Mem_Control_out) begin
            state_d = IND_RD;
            we_d    = 1'b0;
          end else if (is_store_op(opcode)) begin
            state_d = WR;
            we_d    = 1'b1;
          end else begin
            state_d = RD;
            we_d    = 1'b0;
          end
        end
      end
      IND_RD: begin
        // Pointer fetched: req stays up and retargets the final access.
        if (dmem.ack) begin
          addr_d = ADDR_W'(dmem.rdata);
          if (is_store_q) begin
            state_d = WR;
            we_d    = 1'b1;
          end else begin
            state_d = RD;
            we_d    = 1'b0;
          end
        end
      end
      RD: begin
        if (dmem.ack) begin
          memout_d    = dmem.rdata;
          mem_valid_d = 1'b1;
          req_d       = 1'b0;
          state_d     = IDLE;
        end
      end
      WR: begin
        if (dmem.ack) begin
          store_done_d = 1'b1;
          req_d        = 1'b0;
          we_d         = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Watchdog only fires without an ack, so no completion pulse is pending here.
    if (expired) begin
      state_d   = IDLE;
      req_d     = 1'b0;
      we_d      = 1'b0;
      mem_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      memout_q     <= '0;
      is_store_q   <= 1'b0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      mem_valid_q  <= 1'b0;
      store_done_q <= 1'b0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      memout_q     <= memout_d;
      is_store_q   <= is_store_d;
      req_q        <= req_d;
      we_q         <= we_d;
      mem_valid_q  <= mem_valid_d;
      store_done_q <= store_done_d;
      mem_err_q    <= mem_err_d;
    end
  end

  assign dmem.req   = req_q;
  assign dmem.we    = we_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = wdata_q;

  assign memout     = memout_q;
  assign mem_valid  = mem_valid_q;
  assign store_done = store_done_q;
  assign mem_err    = mem_err_q;
  assign stall      = (state_q != IDLE);

endmodule

// File: tb/tb_lc3_mem_access.sv
// Directed bench for lc3_mem_access: memory responder model plus a completion scoreboard.
module tb_lc3_mem_access;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable_mem = 1'b0;
  logic        Mem_Control_out = 1'b0;
  logic [15:0] IR_Exec = 16'h0;
  logic [15:0] pcout = 16'h0;
  logic [15:0] M_Data = 16'h0;
  logic [15:0] memout;
  logic        mem_valid, store_done, stall, mem_err;

  int total = 0;
  int bad = 0;
  int wait_states = 0;

  logic [15:0] mem [logic [15:0]];

  typedef struct packed {
    logic        is_store;
    logic [15:0] addr;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];

  lc3_mem_access_if #(.ADDR_W(16), .DATA_W(16)) dmem ();

  lc3_mem_access #(
    .ADDR_W        (16),
    .DATA_W        (16),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable_mem     (enable_mem),
    .IR_Exec        (IR_Exec),
    .Mem_Control_out(Mem_Control_out),
    .pcout          (pcout),
    .M_Data         (M_Data),
    .dmem           (dmem),
    .memout         (memout),
    .mem_valid      (mem_valid),
    .store_done     (store_done),
    .stall          (stall),
    .mem_err        (mem_err)
  );

  initial forever #5 clock = ~clock;

  function automatic logic [15:0] mem_read(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 16'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [15:0] ir, input logic ind, input logic [15:0] a,
                       input logic [15:0] d);
    IR_Exec         = ir;
    Mem_Control_out = ind;
    pcout           = a;
    M_Data          = d;
    enable_mem      = 1'b1;
  endtask

  // Memory responder: acks after wait_states idle req cycles; a consumed ack starts a new phase.
  initial begin
    int waited;
    waited      = 0;
    dmem.ack    = 1'b0;
    dmem.rdata  = 16'h0;
    forever begin
      @(posedge clock);
      #1;
      if (dmem.ack) dmem.ack = 1'b0;
      if (!reset || !dmem.req) begin
        waited = 0;
      end else if (waited >= wait_states) begin
        dmem.ack = 1'b1;
        if (dmem.we) mem[dmem.addr] = dmem.wdata;
        else dmem.rdata = mem_read(dmem.addr);
        waited = 0;
      end else begin
        waited++;
      end
    end
  end

  // Scoreboard: every completion pulse must match the oldest outstanding operation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && (mem_valid || store_done)) begin
        check("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          if (e.is_store) begin
            check("sb_store_pulse", {mem_valid, store_done}, 2'b01);
            check("sb_store_mem", mem_read(e.addr), e.data);
          end else begin
            check("sb_load_pulse", {mem_valid, store_done}, 2'b10);
            check("sb_load_data", memout, e.data);
          end
        end
      end
    end
  end

  initial begin
    mem[16'h3000] = 16'h1234;
    mem[16'h4000] = 16'h5000;
    mem[16'h3010] = 16'hCAFE;
    mem[16'h3020] = 16'h0F0F;
    mem[16'h3040] = 16'h3050;
    mem[16'h3050] = 16'hA5A5;

    // Reset state
    repeat (2) tick();
    check("rst_req_we", {dmem.req, dmem.we}, 2'b00);
    check("rst_addr", dmem.addr, 16'h0);
    check("rst_wdata", dmem.wdata, 16'h0);
    check("rst_memout", memout, 16'h0);
    check("rst_flags", {mem_valid, store_done, stall, mem_err}, 4'b0000);
    reset = 1'b1;
    tick();

    // LD x3000, zero-wait
    issue(16'h2000, 1'b0, 16'h3000, 16'h0);
    sb.push_back(exp_t'{1'b0, 16'h3000, 16'h1234});
    tick();
    enable_mem = 1'b0;
    check("ld_c1_stall", stall, 1'b1);
    check("ld_c1_req_we", {dmem.req, dmem.we}, 2'b10);
    check("ld_c1_addr", dmem.addr, 16'h3000);
    tick();
    check("ld_c2_valid", mem_valid, 1'b1);
    check("ld_c2_memout", memout, 16'h1234);
    check("ld_c2_idle", {stall, dmem.req}, 2'b00);
    tick();
    check("ld_c3_pulse_end", mem_valid, 1'b0);

    // STI via pointer x4000 -> x5000
    issue(16'hB000, 1'b1, 16'h4000, 16'hBEEF);
    sb.push_back(exp_t'{1'b1, 16'h5000, 16'hBEEF});
    tick();
    enable_mem = 1'b0;
    check("sti_c1_req_we", {stall, dmem.req, dmem.we}, 3'b110);
    check("sti_c1_addr", dmem.addr, 16'h4000);
    tick();
    check("sti_c2_req_we", {stall, dmem.req, dmem.we}, 3'b111);
    check("sti_c2_addr", dmem.addr, 16'h5000);
    check("sti_c2_wdata", dmem.wdata, 16'hBEEF);
    tick();
    check("sti_c3_done", {store_done, stall, dmem.req}, 3'b100);

    // LDR with 4 wait states; enable pulses while busy must be ignored
    wait_states = 4;
    issue(16'h6000, 1'b0, 16'h3010, 16'h0);
    sb.push_back(exp_t'{1'b0, 16'h3010, 16'hCAFE});
    tick();
    enable_mem = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      check("ldr_wait_req", {stall, dmem.req, dmem.we, mem_valid}, 4'b1100);
      check("ldr_wait_addr", dmem.addr, 16'h3010);
      if (c >= 2 && c <= 4) issue(16'h3000, 1'b0, 16'h0BAD, 16'hDEAD);
      else enable_mem = 1'b0;
      tick();
    end
    enable_mem = 1'b0;
    check("ldr_c6_valid", mem_valid, 1'b1);
    check("ldr_c6_memout", memout, 16'hCAFE);
    tick();
    check("ldr_c7_idle", {stall, dmem.req}, 2'b00);
    wait_states = 0;

    // LD then ST accepted in the same cycle mem_valid pulses
    issue(16'h2000, 1'b0, 16'h3020, 16'h0);
    sb.push_back(exp_t'{1'b0, 16'h3020, 16'h0F0F});
    tick();
    enable_mem = 1'b0;
    tick();
    check("b2b_c2_valid", mem_valid, 1'b1);
    issue(16'h3000, 1'b0, 16'h3030, 16'h7777);
    sb.push_back(exp_t'{1'b1, 16'h3030, 16'h7777});
    tick();
    enable_mem = 1'b0;
    check("b2b_c3_wr", {stall, dmem.req, dmem.we}, 3'b111);
    check("b2b_c3_addr", dmem.addr, 16'h3030);
    check("b2b_memout_hold", memout, 16'h0F0F);
    tick();
    check("b2b_c4_done", store_done, 1'b1);
    tick();

    // ADD is not a memory op
    issue(16'h1000, 1'b0, 16'h3000, 16'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("add_no_req", {stall, dmem.req}, 2'b00);
    end
    enable_mem = 1'b0;

    // LDI through pointer x3040 -> x3050
    issue(16'hA000, 1'b1, 16'h3040, 16'h0);
    sb.push_back(exp_t'{1'b0, 16'h3050, 16'hA5A5});
    tick();
    enable_mem = 1'b0;
    check("ldi_c1_addr", dmem.addr, 16'h3040);
    tick();
    check("ldi_c2_addr", dmem.addr, 16'h3050);
    check("ldi_c2_rd", {stall, dmem.req, dmem.we, mem_valid}, 4'b1100);
    tick();
    check("ldi_c3_valid", {mem_valid, stall}, 2'b10);
    check("ldi_c3_memout", memout, 16'hA5A5);
    tick();

    // Reset during a stalled STR write
    wait_states = 100;
    issue(16'h7000, 1'b0, 16'h3060, 16'h1111);
    tick();
    enable_mem = 1'b0;
    tick();
    check("rstmid_wr", {stall, dmem.req, dmem.we}, 3'b111);
    reset = 1'b0;
    #1;
    check("rstmid_req_we", {dmem.req, dmem.we, stall}, 3'b000);
    check("rstmid_addr", dmem.addr, 16'h0);
    check("rstmid_wdata", dmem.wdata, 16'h0);
    check("rstmid_memout", memout, 16'h0);
    repeat (2) tick();
    reset = 1'b1;
    wait_states = 0;
    tick();
    check("rstmid_no_write", mem_read(16'h3060), 16'h0);
    issue(16'h2000, 1'b0, 16'h3000, 16'h0);
    sb.push_back(exp_t'{1'b0, 16'h3000, 16'h1234});
    tick();
    enable_mem = 1'b0;
    tick();
    check("post_rst_ld_valid", mem_valid, 1'b1);
    check("post_rst_ld_memout", memout, 16'h1234);
    tick();

`ifdef LC3_MEM_TIMEOUT_EN
    // No ack: abort after 8 request cycles
    wait_states = 1000;
    issue(16'h2000, 1'b0, 16'h3070, 16'h0);
    tick();
    enable_mem = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      check("to_wait", {stall, dmem.req, mem_err}, 3'b110);
      tick();
    end
    check("to_err", {mem_err, mem_valid, stall, dmem.req}, 4'b1000);
    tick();
    check("to_err_end", {mem_err, stall}, 2'b00);
    wait_states = 0;
`else
    check("no_timeout_err", mem_err, 1'b0);
`endif

    repeat (3) tick();
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
